proc_mem_resp_queue: RTL and testbench
======================================

// Module: proc_mem_resp_queue
// PURPOSE
//  N-entry FIFO on the processor's memory-response path, directly upstream of
//  the drop unit. Decouples memory response timing from the pipeline and holds
//  in-flight responses while the pipeline stalls.
//  Exposes en/rdy on both sides plus a flush input that discards stored responses.
//  Exposes an occupancy count for the request-issue logic.
// PARAMETERS
//  p_msg_nbits    77  width of one memory response message
//  p_num_entries  2   queue depth; legal range 2..16, need not be a power of two
// PORTS
//  clk          in   1                            clock; all state updates on posedge
//  reset        in   1                            asynchronous, active-high
//  flush        in   1                            discard all stored entries this cycle
//  in_msg       in   p_msg_nbits                  enqueue data
//  in_en        in   1                            enqueue fire; sender asserts only when in_rdy=1
//  in_rdy       out  1                            queue can accept a message this cycle
//  out_msg      out  p_msg_nbits                  head-of-queue data
//  out_en       out  1                            dequeue fire (message handed downstream)
//  out_rdy      in   1                            downstream can accept this cycle
//  num_entries  out  $clog2(p_num_entries+1)      current occupancy
// BEHAVIOUR
//  - Clock is clk. reset is asynchronous and active-high.
//  - Reset, applied asynchronously: wr_ptr=0, rd_ptr=0, count=0.
//    While reset is high: out_en=0, in_rdy=0, num_entries=0.
//  - State: wr_ptr, rd_ptr in 0..p_num_entries-1; count in 0..p_num_entries.
//  - Pointers wrap explicitly. A pointer equal to p_num_entries-1 wraps to 0;
//    this is not a modulo 2^k wrap.
//  - in_rdy = !flush && (count != p_num_entries).
//    No full-and-dequeue pass-through: a full queue refuses input even if out_rdy=1.
//  - out_en = !flush && (count != 0) && out_rdy.
//  - out_msg = mem[rd_ptr]. When count==0, out_msg is don't-care.
//  - Enqueue on in_en: mem[wr_ptr] <= in_msg, then wr_ptr advances.
//    Dequeue on out_en: rd_ptr advances.
//  - count update: +1 on enqueue only, -1 on dequeue only, unchanged when both
//    fire in the same cycle (only possible when 0<count<N).
//  - Latency: an enqueued message is visible at out_msg on the next cycle.
//    Minimum latency is 1 cycle.
//  - flush=1:
//    - next-cycle count=0 and rd_ptr<=wr_ptr.
//    - out_en and in_rdy are both forced 0 that cycle, so no handshake can
//      coincide with flush.
//  - in_en while in_rdy=0 is a protocol violation. Simulation asserts on it;
//    RTL behaviour is then undefined.
//  - num_entries = count (registered, no combinational path from inputs).
// CONFIGURATION
//  PROC_MEM_RESP_QUEUE_BYPASS_EN
//   defined: when count==0, in_en=1, out_rdy=1 and flush=0, the message is
//   forwarded combinationally. out_msg=in_msg, out_en=1, nothing is stored,
//   and latency is 0.
//   - in_rdy is unchanged, so there is no out_rdy->in_rdy path.
//   - out_en=in_en when empty and out_rdy=1.
//   undefined: strictly registered, minimum latency 1 cycle. Same as above.
// STRUCTURE
//  - Package proc_mem_resp_queue_pkg:
//    - localparams for default depth and message width
//    - count-width function
//  - Sub-module proc_mem_resp_queue_ctrl holds pointers, count, in_rdy/out_en
//    logic and the flush handling.
//  - Top level holds the p_num_entries x p_msg_nbits register array, write
//    decoder and read mux.
// TESTING
//  - Fill/drain, N=2: enqueue A,B with out_rdy=0 -> in_rdy=0, num_entries=2.
//    Then out_rdy=1 -> A then B out on consecutive cycles, then in_rdy=1.
//  - Wrap, N=3: 7 sequential msgs 0x1..0x7 with random out_rdy -> output order
//    preserved across two pointer wraps.
//  - Simultaneous, count=1: enq C and deq head in same cycle -> count stays 1,
//    next out_msg=C.
//  - Flush, count=2 + in_en=0: flush=1 -> out_en=0 that cycle.
//    Next cycle num_entries=0; a subsequent enqueue of D is the next output.
//  - Reset mid-operation: assert reset asynchronously while count=2 ->
//    out_en, in_rdy, num_entries drop to 0 immediately.
//    After release: empty queue, in_rdy=1.
//  - Bypass (macro on): empty, in_en=1 with 0xAB, out_rdy=1 -> out_en=1 and
//    out_msg=0xAB the same cycle, num_entries stays 0.
//    Macro off: out_en=1 on the next cycle.

Source files
------------

// File: rtl/proc_mem_resp_queue_pkg.sv
// rtl/proc_mem_resp_queue_pkg.sv - shared defaults and sizing helpers for the memory-response queue
//
// Purpose: default depth and message width, and the occupancy-counter width
//          function used by the queue top level and its control block.
// Ports:   none (package).

package proc_mem_resp_queue_pkg;

   localparam int DEFAULT_MSG_NBITS   = 77;
   localparam int DEFAULT_NUM_ENTRIES = 2;

   // Counter must represent 0..n inclusive, so it needs one more code than a pointer.
   function automatic int count_nbits(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/proc_mem_resp_queue_if.sv
// rtl/proc_mem_resp_queue_if.sv - enqueue/dequeue handshake bundle for the memory-response queue
//
// Purpose: groups the en/rdy handshakes and message buses of both queue sides.
// Signals: in_msg/in_en/in_rdy   enqueue side
//          out_msg/out_en/out_rdy dequeue side
// Modports: master - environment (memory side sender and downstream receiver)
//           slave  - the queue itself

interface proc_mem_resp_queue_if #(
   parameter int p_msg_nbits = 77
);
   logic [p_msg_nbits-1:0] in_msg;
   logic                   in_en;
   logic                   in_rdy;
   logic [p_msg_nbits-1:0] out_msg;
   logic                   out_en;
   logic                   out_rdy;

   modport master (
      output in_msg, in_en, out_rdy,
      input  in_rdy, out_msg, out_en
   );

   modport slave (
      input  in_msg, in_en, out_rdy,
      output in_rdy, out_msg, out_en
   );
endinterface

// File: rtl/proc_mem_resp_queue_ctrl.sv
// rtl/proc_mem_resp_queue_ctrl.sv - pointer, occupancy and handshake control for the memory-response queue
//
// Purpose: keeps wr_ptr/rd_ptr/count, derives in_rdy/out_en, handles flush.
// Optional feature: PROC_MEM_RESP_QUEUE_BYPASS_EN enables empty-queue
//                   zero-latency forwarding (bypass output).
// Ports:   clk, reset (async, active-high), flush, in_en, out_rdy   inputs
//          in_rdy, out_en        handshake outputs
//          wr_en, wr_ptr         storage write control
//          rd_ptr                storage read select
//          bypass                out_msg must come from in_msg this cycle
//          num_entries           registered occupancy

module proc_mem_resp_queue_ctrl
   import proc_mem_resp_queue_pkg::*;
#(
   parameter  int p_num_entries = DEFAULT_NUM_ENTRIES,
   localparam int PTR_NBITS     = $clog2(p_num_entries),
   localparam int CNT_NBITS     = count_nbits(p_num_entries)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_en,
   input  logic                 out_rdy,
   output logic                 in_rdy,
   output logic                 out_en,
   output logic                 wr_en,
   output logic                 bypass,
   output logic [PTR_NBITS-1:0] wr_ptr,
   output logic [PTR_NBITS-1:0] rd_ptr,
   output logic [CNT_NBITS-1:0] num_entries
);

   localparam logic [CNT_NBITS-1:0] FULL = CNT_NBITS'(p_num_entries);
   localparam logic [PTR_NBITS-1:0] LAST = PTR_NBITS'(p_num_entries - 1);

   logic [CNT_NBITS-1:0] count;
   logic                 empty;
   logic                 full;
   logic                 rd_en;

   // Depth need not be a power of two, so wrap on the last index rather than on overflow.
   function automatic logic [PTR_NBITS-1:0] ptr_next(input logic [PTR_NBITS-1:0] p);
      return (p == LAST) ? '0 : p + PTR_NBITS'(1);
   endfunction

   assign empty = (count == '0);
   assign full  = (count == FULL);

   // A full queue refuses input even when the head is leaving this cycle.
   assign in_rdy = !reset && !flush && !full;

`ifdef PROC_MEM_RESP_QUEUE_BYPASS_EN
   assign bypass = !reset && !flush && empty && in_en && out_rdy;
`else
   assign bypass = 1'b0;
`endif

   assign out_en = (!reset && !flush && !empty && out_rdy) || bypass;

   // A bypassed message is never stored and never counted.
   assign wr_en = in_en && in_rdy && !bypass;
   assign rd_en = out_en && !bypass;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= wr_ptr;
      end else begin
         if (wr_en) wr_ptr <= ptr_next(wr_ptr);
         if (rd_en) rd_ptr <= ptr_next(rd_ptr);
         if (wr_en && !rd_en)
            count <= count + CNT_NBITS'(1);
         else if (rd_en && !wr_en)
            count <= count - CNT_NBITS'(1);
      end
   end

   assign num_entries = count;

   a_no_enq_when_not_rdy: assert property (@(posedge clk) disable iff (reset) in_en |-> in_rdy);

endmodule

// File: rtl/proc_mem_resp_queue.sv
// rtl/proc_mem_resp_queue.sv - N-entry FIFO on the processor memory-response path
//
// Purpose: decouples memory response timing from the pipeline; holds in-flight
//          responses during stalls; flush discards stored responses.
// Optional feature: PROC_MEM_RESP_QUEUE_BYPASS_EN (zero-latency forwarding
//                   when empty; default build is strictly registered).
// Ports:   clk          clock
//          reset        asynchronous, active-high
//          flush        discard all stored entries this cycle
//          q            handshake bundle (slave): in_msg/in_en/in_rdy,
//                       out_msg/out_en/out_rdy
//          num_entries  registered occupancy

module proc_mem_resp_queue
   import proc_mem_resp_queue_pkg::*;
#(
   parameter int p_msg_nbits   = DEFAULT_MSG_NBITS,
   parameter int p_num_entries = DEFAULT_NUM_ENTRIES
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   flush,
   proc_mem_resp_queue_if.slave                   q,
   output logic [count_nbits(p_num_entries)-1:0] num_entries
);

   localparam int PTR_NBITS = $clog2(p_num_entries);

   logic [p_msg_nbits-1:0]   mem [p_num_entries];
   logic [PTR_NBITS-1:0]     wr_ptr;
   logic [PTR_NBITS-1:0]     rd_ptr;
   logic                     wr_en;
   logic                     bypass;
   logic [p_num_entries-1:0] wr_sel;

   proc_mem_resp_queue_ctrl #(
      .p_num_entries (p_num_entries)
   ) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_en       (q.in_en),
      .out_rdy     (q.out_rdy),
      .in_rdy      (q.in_rdy),
      .out_en      (q.out_en),
      .wr_en       (wr_en),
      .bypass      (bypass),
      .wr_ptr      (wr_ptr),
      .rd_ptr      (rd_ptr),
      .num_entries (num_entries)
   );

   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < p_num_entries; i++)
         wr_sel[i] = wr_en && (wr_ptr == PTR_NBITS'(i));
   end

   // Storage is not reset: an entry is only observed after it has been written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < p_num_entries; i++)
         if (wr_sel[i]) mem[i] <= q.in_msg;
   end

   assign q.out_msg = bypass ? q.in_msg : mem[rd_ptr];

endmodule

// File: tb/tb_proc_mem_resp_queue.sv
// tb/tb_proc_mem_resp_queue.sv - self-checking bench for proc_mem_resp_queue (N=2 and N=3 instances)

module tb_proc_mem_resp_queue;

   localparam int W = 77;
`ifdef PROC_MEM_RESP_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_flush = 1'b0;
   logic [1:0] ne2;
   logic [1:0] ne3;
   int         n_checks = 0;
   int         n_err = 0;

   logic [W-1:0] mq2[$];
   logic [W-1:0] mq3[$];

   proc_mem_resp_queue_if #(.p_msg_nbits(W)) if2 ();
   proc_mem_resp_queue_if #(.p_msg_nbits(W)) if3 ();

   proc_mem_resp_queue #(.p_msg_nbits(W), .p_num_entries(2)) u2 (
      .clk(clk), .reset(reset), .flush(s_flush), .q(if2), .num_entries(ne2));
   proc_mem_resp_queue #(.p_msg_nbits(W), .p_num_entries(3)) u3 (
      .clk(clk), .reset(reset), .flush(s_flush), .q(if3), .num_entries(ne3));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Expected outputs from the queue contents and this cycle's inputs.
   task automatic cmp(input string tag, input int n, input int sz, input logic [W-1:0] head,
                      input logic ie, input logic [W-1:0] im, input logic ordy,
                      input logic ir, input logic oe, input logic [W-1:0] om, input logic [1:0] ne);
      logic e_ir, e_oe;
      e_ir = !reset && !s_flush && (sz < n);
      e_oe = !reset && !s_flush && ordy && ((sz > 0) || (BYP && ie));
      chk({tag, ".in_rdy"}, 128'(ir), 128'(e_ir));
      chk({tag, ".out_en"}, 128'(oe), 128'(e_oe));
      chk({tag, ".num_entries"}, 128'(ne), 128'(sz));
      if (e_oe) chk({tag, ".out_msg"}, 128'(om), 128'((sz > 0) ? head : im));
   endtask

   always @(negedge clk) begin
      #3;
      cmp("u2", 2, mq2.size(), (mq2.size() > 0) ? mq2[0] : '0, if2.in_en, if2.in_msg,
          if2.out_rdy, if2.in_rdy, if2.out_en, if2.out_msg, ne2);
      cmp("u3", 3, mq3.size(), (mq3.size() > 0) ? mq3[0] : '0, if3.in_en, if3.in_msg,
          if3.out_rdy, if3.in_rdy, if3.out_en, if3.out_msg, ne3);
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq2.delete();
         mq3.delete();
      end else if (s_flush) begin
         mq2.delete();
         mq3.delete();
      end else begin
         if (!(BYP && mq2.size() == 0 && if2.in_en && if2.out_rdy)) begin
            if (if2.out_rdy && mq2.size() > 0) void'(mq2.pop_front());
            if (if2.in_en) mq2.push_back(if2.in_msg);
         end
         if (!(BYP && mq3.size() == 0 && if3.in_en && if3.out_rdy)) begin
            if (if3.out_rdy && mq3.size() > 0) void'(mq3.pop_front());
            if (if3.in_en) mq3.push_back(if3.in_msg);
         end
      end
   end

   // Inputs change just after the falling edge; in_en is only raised where in_rdy allows it.
   task automatic step(input logic w, input logic [W-1:0] m, input logic ordy, input logic fl);
      @(negedge clk);
      s_flush     = fl;
      if2.out_rdy = ordy;
      if3.out_rdy = ordy;
      if2.in_msg  = m;
      if3.in_msg  = m;
      if2.in_en   = 1'b0;
      if3.in_en   = 1'b0;
      #1;
      if2.in_en = w & if2.in_rdy;
      if3.in_en = w & if3.in_rdy;
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [7:0] got[$];
      int         nxt;

      if2.in_msg = '0; if2.in_en = 1'b0; if2.out_rdy = 1'b0;
      if3.in_msg = '0; if3.in_en = 1'b0; if3.out_rdy = 1'b0;

      // Reset state
      #3;
      chk("rst.in_rdy", 128'(if2.in_rdy), 128'(0));
      chk("rst.num_entries", 128'(ne2), 128'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Fill/drain on N=2
      step(1'b1, W'(77'hA), 1'b0, 1'b0);
      step(1'b1, W'(77'hB), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0); #3;
      chk("fill.in_rdy", 128'(if2.in_rdy), 128'(0));
      chk("fill.num_entries", 128'(ne2), 128'(2));
      step(1'b0, '0, 1'b1, 1'b0); #3;
      chk("drain.first_en", 128'(if2.out_en), 128'(1));
      chk("drain.first_msg", 128'(if2.out_msg), 128'(77'hA));
      step(1'b0, '0, 1'b1, 1'b0); #3;
      chk("drain.second_msg", 128'(if2.out_msg), 128'(77'hB));
      step(1'b0, '0, 1'b1, 1'b0); #3;
      chk("drain.in_rdy", 128'(if2.in_rdy), 128'(1));
      chk("drain.num_entries", 128'(ne2), 128'(0));

      // Simultaneous enqueue/dequeue at count=1
      step(1'b1, W'(77'h5A), 1'b0, 1'b0);
      step(1'b1, W'(77'hC), 1'b1, 1'b0); #3;
      chk("simul.out_msg", 128'(if2.out_msg), 128'(77'h5A));
      step(1'b0, '0, 1'b0, 1'b0); #3;
      chk("simul.num_entries", 128'(ne2), 128'(1));
      chk("simul.next_msg", 128'(if2.out_msg), 128'(77'hC));
      drain();

      // Flush at count=2
      step(1'b1, W'(77'hE1), 1'b0, 1'b0);
      step(1'b1, W'(77'hE2), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1); #3;
      chk("flush.out_en", 128'(if2.out_en), 128'(0));
      chk("flush.in_rdy", 128'(if2.in_rdy), 128'(0));
      step(1'b0, '0, 1'b0, 1'b0); #3;
      chk("flush.num_entries", 128'(ne2), 128'(0));
      step(1'b1, W'(77'hD), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0); #3;
      chk("flush.d_msg", 128'(if2.out_msg), 128'(77'hD));
      drain();

      // Bypass behaviour on an empty queue
      step(1'b1, W'(77'hAB), 1'b1, 1'b0); #3;
`ifdef PROC_MEM_RESP_QUEUE_BYPASS_EN
      chk("byp.out_en", 128'(if2.out_en), 128'(1));
      chk("byp.out_msg", 128'(if2.out_msg), 128'(77'hAB));
      step(1'b0, '0, 1'b0, 1'b0); #3;
      chk("byp.num_entries", 128'(ne2), 128'(0));
`else
      chk("nobyp.out_en_same", 128'(if2.out_en), 128'(0));
      step(1'b0, '0, 1'b1, 1'b0); #3;
      chk("nobyp.out_en_next", 128'(if2.out_en), 128'(1));
      chk("nobyp.out_msg", 128'(if2.out_msg), 128'(77'hAB));
`endif
      drain();

      // Wrap on N=3: 0x1..0x7 with random out_rdy
      nxt = 1;
      for (int c = 0; c < 300 && got.size() < 7; c++) begin
         step(nxt <= 7, W'(nxt), 1'($urandom_range(0, 1)), 1'b0); #3;
         if (if3.out_en) got.push_back(if3.out_msg[7:0]);
         if (if3.in_en) nxt++;
      end
      chk("wrap.count", 128'(got.size()), 128'(7));
      for (int i = 0; i < 7; i++)
         chk($sformatf("wrap.msg%0d", i), 128'((i < got.size()) ? got[i] : 8'h0), 128'(i + 1));
      drain();

      // Random traffic checked by the model
      for (int c = 0; c < 400; c++)
         step(1'($urandom_range(0, 1)), W'({$urandom, $urandom, $urandom}),
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      drain();

      // Asynchronous reset mid-operation
      step(1'b1, W'(77'hF1), 1'b0, 1'b0);
      step(1'b1, W'(77'hF2), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0); #3;
      chk("rstmid.pre_count", 128'(ne2), 128'(2));
      if2.out_rdy = 1'b1;
      if3.out_rdy = 1'b1;
      #1;
      chk("rstmid.pre_out_en", 128'(if2.out_en), 128'(1));
      #1 reset = 1'b1;
      #1;
      chk("rstmid.out_en", 128'(if2.out_en), 128'(0));
      chk("rstmid.in_rdy", 128'(if3.in_rdy), 128'(0));
      chk("rstmid.num2", 128'(ne2), 128'(0));
      chk("rstmid.num3", 128'(ne3), 128'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      step(1'b0, '0, 1'b0, 1'b0); #3;
      chk("rstmid.post_in_rdy", 128'(if2.in_rdy), 128'(1));
      chk("rstmid.post_num", 128'(ne2), 128'(0));

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
